// File: rtl/pulpino_boot_pkg.sv
// Shared types and constants for the PULPino boot sequencer.
// The watchdog is built only when PULPINO_BOOT_WDT_EN is defined.
package pulpino_boot_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } boot_state_e;

  localparam int REBOOT_CNT_W = 8;
  localparam logic [REBOOT_CNT_W-1:0] REBOOT_CNT_MAX = 8'hFF;

  function automatic logic [REBOOT_CNT_W-1:0] sat_inc(
    input logic [REBOOT_CNT_W-1:0] v
  );
    return (v == REBOOT_CNT_MAX) ? v : v + REBOOT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulpino_boot_debounce.sv
// Boot button path: 2-FF synchronizer, debouncer, registered press pulse.
// Part of pulpino_boot_ctrl (watchdog macro PULPINO_BOOT_WDT_EN).
module pulpino_boot_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      lvl     <= 1'b0;
      lvl_d   <= 1'b0;
      cnt     <= '0;
      press_o <= 1'b0;
    end else begin
      s1      <= btn_i;
      s2      <= s1;
      lvl_d   <= lvl;
      press_o <= lvl & ~lvl_d;
      // any sample matching the current level restarts the run
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pulpino_boot_ctrl.sv
// Board boot sequencer for the PULPino SoC: reset hold, fetch enable.
// Optional heartbeat watchdog enabled by macro PULPINO_BOOT_WDT_EN.
module pulpino_boot_ctrl
  import pulpino_boot_pkg::*;
#(
  parameter int RST_HOLD_CYCLES   = 16,
  parameter int BOOT_DELAY_CYCLES = 64,
  parameter int DEBOUNCE_CYCLES   = 8,
  parameter int WDT_CYCLES        = 1000000,
  parameter int AUTO_BOOT         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked_i,
  input  logic                    fetch_btn_i,
  input  logic                    heartbeat_i,
  output logic                    soc_rst_n_o,
  output logic                    fetch_enable_o,
  output logic                    running_o,
  output logic                    wdt_trip_o,
  output logic [REBOOT_CNT_W-1:0] reboot_cnt_o
);

  localparam int PH_MAX = (RST_HOLD_CYCLES > BOOT_DELAY_CYCLES) ?
                          RST_HOLD_CYCLES : BOOT_DELAY_CYCLES;
  localparam int PH_W = $clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(RST_HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] BOOT_LAST = PH_W'(BOOT_DELAY_CYCLES - 1);
  localparam boot_state_e AFTER_WAIT = (AUTO_BOOT != 0) ? RUN : ARMED;

  boot_state_e     state;
  boot_state_e     state_d;
  logic [PH_W-1:0] cnt;
  logic [PH_W-1:0] cnt_d;
  logic            press;

  pulpino_boot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (fetch_btn_i),
    .press_o(press)
  );

`ifdef PULPINO_BOOT_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0]        wdt;
  logic [WDT_W-1:0]        wdt_d;
  logic                    hb_q;
  logic                    trip_d;
  logic                    trip_q;
  logic [REBOOT_CNT_W-1:0] reboot;
  logic [REBOOT_CNT_W-1:0] reboot_d;

  assign wdt_trip_o   = trip_q;
  assign reboot_cnt_o = reboot;
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_hb;

  assign unused_hb    = heartbeat_i;
  assign wdt_trip_o   = 1'b0;
  assign reboot_cnt_o = '0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
`ifdef PULPINO_BOOT_WDT_EN
    // wdt sits at zero outside RUN, so RUN is always entered cleared
    wdt_d    = '0;
    trip_d   = 1'b0;
    reboot_d = reboot;
`endif
    if (!pll_locked_i) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + PH_W'(1);
          end
        end
        WAIT: begin
          if (cnt == BOOT_LAST) begin
            state_d = AFTER_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + PH_W'(1);
          end
        end
        ARMED: begin
          if (press) state_d = RUN;
        end
        RUN: begin
`ifdef PULPINO_BOOT_WDT_EN
          if (heartbeat_i != hb_q) begin
            wdt_d = '0;
          end else if (wdt == WDT_LAST) begin
            trip_d   = 1'b1;
            reboot_d = sat_inc(reboot);
            state_d  = HOLD;
            cnt_d    = '0;
          end else begin
            wdt_d = wdt + WDT_W'(1);
          end
`endif
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HOLD;
      cnt            <= '0;
      soc_rst_n_o    <= 1'b0;
      fetch_enable_o <= 1'b0;
      running_o      <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      soc_rst_n_o    <= (state_d != HOLD);
      fetch_enable_o <= (state_d == RUN);
      running_o      <= (state_d == RUN);
    end
  end

`ifdef PULPINO_BOOT_WDT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt    <= '0;
      hb_q   <= 1'b0;
      trip_q <= 1'b0;
      reboot <= '0;
    end else begin
      wdt    <= wdt_d;
      hb_q   <= heartbeat_i;
      trip_q <= trip_d;
      reboot <= reboot_d;
    end
  end
`endif

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Bench for pulpino_boot_ctrl: an auto-boot and a button-boot instance
// checked every cycle against a behavioural model plus literal checks.
module tb_pulpino_boot_ctrl;

  localparam int R = 4;
  localparam int B = 8;
  localparam int D = 8;
  localparam int W = 20;
  localparam int P_HOLD  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ARMED = 2;
  localparam int P_RUN   = 3;
`ifdef PULPINO_BOOT_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll = 1'b1;
  logic btn = 1'b0;
  logic hb  = 1'b0;
  logic hb_en = 1'b1;

  logic [1:0] soc_rst_n;
  logic [1:0] fetch;
  logic [1:0] running;
  logic [1:0] trip;
  logic [7:0] reboot [2];

  int checks = 0;
  int errors = 0;
  int trips_a = 0;
  int trips_m = 0;

  always #5 clk = ~clk;

  pulpino_boot_ctrl #(
    .RST_HOLD_CYCLES(R), .BOOT_DELAY_CYCLES(B),
    .DEBOUNCE_CYCLES(D), .WDT_CYCLES(W), .AUTO_BOOT(1)
  ) u_auto (
    .clk(clk), .rst(rst), .pll_locked_i(pll),
    .fetch_btn_i(btn), .heartbeat_i(hb),
    .soc_rst_n_o(soc_rst_n[0]), .fetch_enable_o(fetch[0]),
    .running_o(running[0]), .wdt_trip_o(trip[0]),
    .reboot_cnt_o(reboot[0])
  );

  pulpino_boot_ctrl #(
    .RST_HOLD_CYCLES(R), .BOOT_DELAY_CYCLES(B),
    .DEBOUNCE_CYCLES(D), .WDT_CYCLES(W), .AUTO_BOOT(0)
  ) u_man (
    .clk(clk), .rst(rst), .pll_locked_i(pll),
    .fetch_btn_i(btn), .heartbeat_i(hb),
    .soc_rst_n_o(soc_rst_n[1]), .fetch_enable_o(fetch[1]),
    .running_o(running[1]), .wdt_trip_o(trip[1]),
    .reboot_cnt_o(reboot[1])
  );

  // ---------------- behavioural model ----------------
  int m_ph  [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_wdt [2] = '{0, 0};
  int m_reb [2] = '{0, 0};
  bit m_trip[2] = '{0, 0};
  bit m_deb = 1'b0;
  bit m_hb_prev = 1'b0;
  int edge_no = 0;
  int press_due = -1;
  bit rawq[$];
  bit seenq[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_HOLD; m_cnt[i] = 0; m_wdt[i] = 0;
      m_reb[i] = 0; m_trip[i] = 1'b0;
    end
    m_deb = 1'b0; m_hb_prev = 1'b0;
    edge_no = 0; press_due = -1;
    rawq.delete(); seenq.delete();
  endtask

  task automatic model_step();
    bit sync_now;
    bit flip;
    bit press_now;
    edge_no++;
    press_now = (edge_no == press_due);
    // the synchronizer shows the level sampled two edges ago
    sync_now = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 1'b0;
    rawq.push_back(btn);
    if (rawq.size() > 4) void'(rawq.pop_front());
    seenq.push_back(sync_now);
    if (seenq.size() > D) void'(seenq.pop_front());
    flip = (seenq.size() == D);
    foreach (seenq[k]) if (seenq[k] == m_deb) flip = 1'b0;
    if (flip) begin
      m_deb = ~m_deb;
      if (m_deb) press_due = edge_no + 2;
    end
    for (int i = 0; i < 2; i++) begin
      m_trip[i] = 1'b0;
      if (!pll) begin
        m_ph[i] = P_HOLD; m_cnt[i] = 0;
      end else begin
        case (m_ph[i])
          P_HOLD: begin
            m_cnt[i]++;
            if (m_cnt[i] == R) begin m_ph[i] = P_WAIT; m_cnt[i] = 0; end
          end
          P_WAIT: begin
            m_cnt[i]++;
            if (m_cnt[i] == B) begin
              m_cnt[i] = 0; m_wdt[i] = 0;
              m_ph[i] = (i == 0) ? P_RUN : P_ARMED;
            end
          end
          P_ARMED: begin
            if (press_now) begin m_ph[i] = P_RUN; m_wdt[i] = 0; end
          end
          default: begin
            if (WDT_ON) begin
              if (hb != m_hb_prev) m_wdt[i] = 0;
              else begin
                m_wdt[i]++;
                if (m_wdt[i] == W) begin
                  m_trip[i] = 1'b1;
                  if (m_reb[i] < 255) m_reb[i]++;
                  m_ph[i] = P_HOLD; m_cnt[i] = 0; m_wdt[i] = 0;
                end
              end
            end
          end
        endcase
      end
    end
    m_hb_prev = hb;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      string n;
      n = (i == 0) ? "auto" : "man";
      chk({n, "_soc_rst_n"}, int'(soc_rst_n[i]), int'(m_ph[i] != P_HOLD));
      chk({n, "_fetch"}, int'(fetch[i]), int'(m_ph[i] == P_RUN));
      chk({n, "_running"}, int'(running[i]), int'(m_ph[i] == P_RUN));
      chk({n, "_trip"}, int'(trip[i]), int'(m_trip[i]));
      chk({n, "_reboot"}, int'(reboot[i]), m_reb[i]);
    end
    if (trip[0] === 1'b1) trips_a++;
    if (trip[1] === 1'b1) trips_m++;
  end

  initial begin : hbp
    int c;
    c = 0;
    forever begin
      @(posedge clk); #3;
      if (hb_en) begin
        c++;
        if (c == 10) begin c = 0; hb = ~hb; end
      end
    end
  end

  task automatic adv(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_soc", int'(soc_rst_n[0]), 0);
    chk("rst_fetch", int'(fetch[0]), 0);
    chk("rst_reboot", int'(reboot[0]), 0);
    rst = 1'b0;

    adv(3);  chk("hold_e3", int'(soc_rst_n[0]), 0);
    adv(1);  chk("rel_e4", int'(soc_rst_n[0]), 1);
    adv(7);  chk("fetch_e11", int'(fetch[0]), 0);
    adv(1);  chk("fetch_e12", int'(fetch[0]), 1);
    chk("run_e12", int'(running[0]), 1);
    chk("man_armed_soc", int'(soc_rst_n[1]), 1);
    chk("man_armed_fetch", int'(fetch[1]), 0);

    pll = 1'b0;
    adv(1);  chk("pll_loss", int'(soc_rst_n[0]), 0);
    pll = 1'b1;
    adv(4);  chk("relock", int'(soc_rst_n[0]), 1);
    adv(2);  pll = 1'b0;
    adv(1);  chk("wait_drop", int'(soc_rst_n[0]), 0);
    pll = 1'b1;
    adv(3);  chk("rehold3", int'(soc_rst_n[0]), 0);
    adv(1);  chk("rehold4", int'(soc_rst_n[0]), 1);
    adv(7);  chk("reboot_f11", int'(fetch[0]), 0);
    adv(1);  chk("reboot_f12", int'(fetch[0]), 1);

    repeat (2) begin
      btn = 1'b1; adv(3);
      btn = 1'b0; adv(1);
    end
    adv(20); chk("bounce", int'(fetch[1]), 0);
    btn = 1'b1;
    adv(11); chk("press11", int'(fetch[1]), 0);
    adv(1);  chk("press12", int'(fetch[1]), 1);
    btn = 1'b0;
    chk("auto_ign_btn", int'(fetch[0]), 1);
    chk("no_trip_toggle", trips_a, 0);

`ifdef PULPINO_BOOT_WDT_EN
    hb_en = 1'b0;
    adv(1);  hb = ~hb;
    adv(20); chk("wdt_e19", int'(trip[0]), 0);
    adv(1);  chk("wdt_trip", int'(trip[0]), 1);
    chk("wdt_reboot1", int'(reboot[0]), 1);
    chk("wdt_soc", int'(soc_rst_n[0]), 0);
    chk("wdt_man_reb", int'(reboot[1]), 1);
    adv(1);  chk("trip_1cyc", int'(trip[0]), 0);
    adv(3);  chk("wdt_reboot_soc", int'(soc_rst_n[0]), 1);
    adv(8);  chk("wdt_reboot_fetch", int'(fetch[0]), 1);
    for (int k = 0; k < 9000 && trips_a < 258; k++) adv(1);
    chk("trip_count", trips_a, 258);
    chk("reboot_sat", int'(reboot[0]), 255);
    chk("man_reb_kept", int'(reboot[1]), 1);
`else
    hb_en = 1'b0;
    adv(1000);
    chk("nowdt_run", int'(running[0]), 1);
    chk("nowdt_trips", trips_a + trips_m, 0);
    chk("nowdt_reboot", int'(reboot[0]), 0);
`endif

    for (int k = 0; k < 100 && running[0] !== 1'b1; k++) adv(1);
    chk("pre_rst_run", int'(running[0]), 1);
    rst = 1'b1;
    #1;
    chk("arst_soc", int'(soc_rst_n[0]), 0);
    chk("arst_fetch", int'(fetch[0]), 0);
    chk("arst_run", int'(running[0]), 0);
    chk("arst_trip", int'(trip[0]), 0);
    chk("arst_reboot", int'(reboot[0]), 0);
    adv(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
